// File: rtl/rbr_add_subb_acc_if.sv
// rtl/rbr_add_subb_acc_if.sv - operand/result stream bundle for the RBR accumulator
interface rbr_add_subb_acc_if #(
  parameter int W  = 64,
  parameter int G  = 4,
  parameter int CW = 8
);
  localparam int N = W + G;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_last;
  logic [2*W-1:0]   a;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out_s;
  logic [CW-1:0]    out_cnt;
  logic             out_ovf;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, in_op, in_last, a, out_ready,
    input  in_ready, out_valid, out_s, out_cnt, out_ovf
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_op, in_last, a, out_ready,
    output in_ready, out_valid, out_s, out_cnt, out_ovf
  );
endinterface

// File: rtl/rbr_add_subb_acc.sv
// rtl/rbr_add_subb_acc.sv - multi-operand redundant binary accumulator with stream handshake
module rbr_add_subb_acc #(
  parameter int W  = 64,
  parameter int G  = 4,
  parameter int CW = 8
) (
  input logic                clk,
  input logic                rst_n,
  rbr_add_subb_acc_if.slave  bus
);
  localparam int N = W + G;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic            out_valid_q;

  logic            accept;
  logic            start;
  logic            is_load;
  logic [2*N-1:0]  op_ext;
  logic [2*N-1:0]  op_y;
  logic [2*N-1:0]  sum;
  logic [N:0]      ch;
  logic [N:0]      cl;
  logic            carry_nz;

  assign bus.in_ready  = (state != ST_DONE) | bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = acc;
  assign bus.out_cnt   = cnt;
  assign bus.out_ovf   = ovf;

  assign accept  = bus.in_valid & bus.in_ready;
  // Any beat accepted outside ACC opens a new frame (IDLE, or DONE with a same-cycle pop).
  assign start   = accept & (state != ST_ACC);
  assign is_load = start | bus.in_op[1];

  // Guard digits are zero (01); subtract / load-negated invert the whole extended word.
  assign op_ext = {{G{2'b01}}, bus.a};
  assign op_y   = bus.in_op[0] ? ~op_ext : op_ext;

  // Two full adders per digit: ch only depends on this digit, cl only on ch one digit down,
  // so there is no ripple across the word.
  always_comb begin
    logic t;
    ch    = '0;
    cl    = '0;
    sum   = '0;
    t     = 1'b0;
    ch[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      t           = acc[2*i+1] ^ acc[2*i] ^ op_y[2*i+1];
      ch[i+1]     = (acc[2*i+1] & acc[2*i]) | (acc[2*i+1] & op_y[2*i+1]) |
                    (acc[2*i] & op_y[2*i+1]);
      sum[2*i+1]  = t ^ op_y[2*i] ^ ch[i];
      cl[i+1]     = (t & op_y[2*i]) | (t & ch[i]) | (op_y[2*i] & ch[i]);
      sum[2*i]    = cl[i];
    end
  end

  // Discarded carry digit is nonzero when it reads 00 or 11.
  assign carry_nz = (ch[N] == cl[N]);

  // Frame FSM: accumulator, operand count, sticky overflow and registered out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= {N{2'b01}};
      cnt         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc <= is_load ? op_y : sum;
            if (start) begin
              cnt <= {{(CW-1){1'b0}}, 1'b1};
              ovf <= 1'b0;
            end else begin
              cnt <= (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
              ovf <= ovf | (~bus.in_op[1] & carry_nz);
            end
            state       <= bus.in_last ? ST_DONE : ST_ACC;
            out_valid_q <= bus.in_last;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            if (accept) begin
              acc         <= op_y;
              cnt         <= {{(CW-1){1'b0}}, 1'b1};
              ovf         <= 1'b0;
              state       <= bus.in_last ? ST_DONE : ST_ACC;
              out_valid_q <= bus.in_last;
            end else begin
              state       <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
